// File: rtl/cfglut5_loader_if.sv
// Handshake and serial-chain signals between the configuration source,
// the cfglut5_loader and the CFGLUT5 chain.
interface cfglut5_loader_if #(
    parameter int unsigned LUT_CNT = 1
);
    localparam int unsigned L = 32 * LUT_CNT;

    logic         s_valid;
    logic         s_ready;
    logic [L-1:0] s_init;
    logic         cfg_ce;
    logic         cfg_cdi;
    logic         cfg_cdo;
    logic         busy;
    logic         done;
    logic         err;

    modport master (
        output s_valid, s_init, cfg_cdo,
        input  s_ready, cfg_ce, cfg_cdi, busy, done, err
    );

    modport slave (
        input  s_valid, s_init, cfg_cdo,
        output s_ready, cfg_ce, cfg_cdi, busy, done, err
    );
endinterface

// File: rtl/cfglut5_loader.sv
// Serial loader for a CFGLUT5 daisy chain: shifts truth tables MSB-first,
// then optionally recirculates the chain once to read it back and flag errors.
module cfglut5_loader #(
    parameter int unsigned LUT_CNT = 1,
    parameter bit          VERIFY  = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cfglut5_loader_if.slave  bus
);
    localparam int unsigned L     = 32 * LUT_CNT;
    localparam int unsigned CNT_W = $clog2(L);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_VERIFY,
        ST_FIN
    } state_t;

    state_t             r_state;
    logic [L-1:0]       r_data;
    logic [L-1:0]       r_shadow;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ready;
    logic               r_ce;
    logic               r_cdi;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic w_accept;
    logic w_last;
    logic w_mismatch;

    assign w_accept   = bus.s_valid & r_ready;
    assign w_last     = (r_cnt == '0);
    assign w_mismatch = bus.cfg_cdo ^ r_shadow[L-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_data   <= '0;
            r_shadow <= '0;
            r_cnt    <= '0;
            r_ready  <= 1'b1;
            r_ce     <= 1'b0;
            r_cdi    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // r_cdi carries the MSB; r_data keeps the remaining bits
                        r_cdi    <= bus.s_init[L-1];
                        r_data   <= {bus.s_init[L-2:0], 1'b0};
                        r_shadow <= bus.s_init;
                        r_err    <= 1'b0;
                        r_cnt    <= CNT_W'(L - 1);
                        r_ready  <= 1'b0;
                        r_ce     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_cdi  <= r_data[L-1];
                    r_data <= {r_data[L-2:0], 1'b0};
                    if (w_last) begin
                        r_cdi <= 1'b0;
                        if (VERIFY) begin
                            r_cnt   <= CNT_W'(L - 1);
                            r_state <= ST_VERIFY;
                        end else begin
                            r_ce    <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= ST_FIN;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (w_mismatch) begin
                        r_err <= 1'b1;
                    end
                    r_shadow <= {r_shadow[L-2:0], 1'b0};
                    if (w_last) begin
                        r_ce    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIN: begin
                    r_ready <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Readback recirculates CDO straight into CDI so the chain contents survive.
    assign bus.cfg_cdi = (r_state == ST_VERIFY) ? bus.cfg_cdo : r_cdi;
    assign bus.s_ready = r_ready;
    assign bus.cfg_ce  = r_ce;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.err     = r_err;
endmodule

// File: tb/tb_cfglut5_loader.sv
// Bench for cfglut5_loader: three configurations driving behavioural
// CFGLUT5 chain models, table-driven loads plus back-to-back and reset cases.
module tb_cfglut5_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cfglut5_loader_if #(.LUT_CNT(1)) if_a ();
    cfglut5_loader_if #(.LUT_CNT(2)) if_b ();
    cfglut5_loader_if #(.LUT_CNT(1)) if_c ();

    cfglut5_loader #(.LUT_CNT(1), .VERIFY(1'b1)) u_a (.i_clk(clk), .i_rst(rst), .bus(if_a.slave));
    cfglut5_loader #(.LUT_CNT(2), .VERIFY(1'b1)) u_b (.i_clk(clk), .i_rst(rst), .bus(if_b.slave));
    cfglut5_loader #(.LUT_CNT(1), .VERIFY(1'b0)) u_c (.i_clk(clk), .i_rst(rst), .bus(if_c.slave));

    // Chain models: bit 32k+i is bit i of LUT k; CDO is the top bit of the last LUT.
    logic        stuck_a = 1'b0;
    logic [31:0] chain_a = '0;
    logic [63:0] chain_b = '0;
    logic [31:0] chain_c = '0;

    always @(posedge clk) begin
        if (if_a.cfg_ce) chain_a <= {chain_a[30:0], if_a.cfg_cdi} & ~(stuck_a ? 32'h0000_0080 : 32'h0);
        if (if_b.cfg_ce) chain_b <= {chain_b[62:0], if_b.cfg_cdi};
        if (if_c.cfg_ce) chain_c <= {chain_c[30:0], if_c.cfg_cdi};
    end

    assign if_a.cfg_cdo = chain_a[31];
    assign if_b.cfg_cdo = chain_b[63];
    assign if_c.cfg_cdo = chain_c[31];

    typedef struct {
        int          inst;
        logic [63:0] init;
        logic        stuck;
        logic [63:0] exp_load;
        logic [63:0] exp_final;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        ce, cdi, done, ready, busy, err;
        logic [63:0] chain;
    } sig_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic get_sig(input int inst, output sig_t s);
        case (inst)
            0: begin
                s.ce = if_a.cfg_ce; s.cdi = if_a.cfg_cdi; s.done = if_a.done;
                s.ready = if_a.s_ready; s.busy = if_a.busy; s.err = if_a.err; s.chain = 64'(chain_a);
            end
            1: begin
                s.ce = if_b.cfg_ce; s.cdi = if_b.cfg_cdi; s.done = if_b.done;
                s.ready = if_b.s_ready; s.busy = if_b.busy; s.err = if_b.err; s.chain = chain_b;
            end
            default: begin
                s.ce = if_c.cfg_ce; s.cdi = if_c.cfg_cdi; s.done = if_c.done;
                s.ready = if_c.s_ready; s.busy = if_c.busy; s.err = if_c.err; s.chain = 64'(chain_c);
            end
        endcase
    endtask

    task automatic drive(input int inst, input logic v, input logic [63:0] d);
        case (inst)
            0:       begin if_a.s_valid = v; if_a.s_init = d[31:0]; end
            1:       begin if_b.s_valid = v; if_b.s_init = d;       end
            default: begin if_c.s_valid = v; if_c.s_init = d[31:0]; end
        endcase
    endtask

    task automatic wait_ready(input int inst);
        sig_t s;
        int   guard;
        guard = 0;
        get_sig(inst, s);
        while (!s.ready && guard < 200) begin
            @(posedge clk); #1;
            get_sig(inst, s);
            guard++;
        end
        chk("ready_wait", 64'(s.ready), 64'd1);
    endtask

    task automatic run_vec(input vec_t v);
        sig_t        s;
        int          len, passes, last;
        int          ce_bad, done_bad, cdi_bad;
        logic [63:0] seq;
        len    = (v.inst == 1) ? 64 : 32;
        passes = (v.inst == 2) ? 1 : 2;
        last   = passes * len + 2;
        ce_bad = 0; done_bad = 0; cdi_bad = 0; seq = '0;
        if (v.inst == 0) stuck_a = v.stuck;
        wait_ready(v.inst);
        drive(v.inst, 1'b1, v.init);
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) drive(v.inst, 1'b0, ~v.init);
            get_sig(v.inst, s);
            if (cyc == 1) begin
                chk("err_clear_on_accept", 64'(s.err), 64'd0);
                chk("busy_not_ready", 64'({s.busy, s.ready}), 64'b10);
            end
            if (s.ce !== (cyc <= passes * len)) ce_bad++;
            if (s.done !== (cyc == passes * len + 1)) done_bad++;
            if (!s.ce && s.cdi !== 1'b0) cdi_bad++;
            if (cyc <= len) seq[len - cyc] = s.cdi;
            if (cyc == len + 1) chk("chain_after_load", s.chain, v.exp_load);
        end
        chk("ce_window", 64'(ce_bad), 64'd0);
        chk("done_pulse", 64'(done_bad), 64'd0);
        chk("cdi_zero_when_idle", 64'(cdi_bad), 64'd0);
        chk("cdi_msb_first_seq", seq, v.init);
        chk("ready_after_fin", 64'({s.ready, s.busy}), 64'b10);
        chk("err_sticky", 64'(s.err), 64'(v.exp_err));
        chk("chain_final", s.chain, v.exp_final);
    endtask

    vec_t vecs[9];

    initial begin
        sig_t s;
        int   bad;
        vec_t rv;

        vecs[0] = '{0, 64'hDEADBEEF, 1'b0, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0};
        vecs[1] = '{0, 64'hFFFFFFFF, 1'b1, 64'h0000007F, 64'h00000000, 1'b1};
        vecs[2] = '{0, 64'h0000FFFF, 1'b0, 64'h0000FFFF, 64'h0000FFFF, 1'b0};
        vecs[3] = '{0, 64'h00000000, 1'b1, 64'h00000000, 64'h00000000, 1'b0};
        vecs[4] = '{0, 64'h80000001, 1'b0, 64'h80000001, 64'h80000001, 1'b0};
        vecs[5] = '{1, 64'h12345678_9ABCDEF0, 1'b0, 64'h12345678_9ABCDEF0, 64'h12345678_9ABCDEF0, 1'b0};
        vecs[6] = '{1, 64'hFFFFFFFF_00000000, 1'b0, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000, 1'b0};
        vecs[7] = '{2, 64'hAAAAAAAA, 1'b0, 64'hAAAAAAAA, 64'hAAAAAAAA, 1'b0};
        vecs[8] = '{2, 64'h00000001, 1'b0, 64'h00000001, 64'h00000001, 1'b0};

        for (int i = 0; i < 3; i++) drive(i, 1'b0, 64'h0);
        #12;
        get_sig(0, s);
        chk("reset_state", 64'({s.ready, s.ce, s.cdi, s.busy, s.done, s.err}), 64'b100000);
        #1 rst = 1'b0;

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Back-to-back on the load-only instance; S_INIT changes mid-load.
        wait_ready(2);
        drive(2, 1'b1, 64'h0F1E2D3C);
        for (int cyc = 1; cyc <= 67; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 5) drive(2, 1'b1, 64'hC3B4A596);
            get_sig(2, s);
            if (cyc == 33) chk("b2b_first_done_image", {63'(s.chain[31:0]), s.done}, {63'h0F1E2D3C, 1'b1});
            if (cyc == 34) chk("b2b_idle_ready", 64'({s.ready, s.ce}), 64'b10);
            if (cyc == 35) begin
                chk("b2b_second_accept", 64'({s.ce, s.ready}), 64'b10);
                drive(2, 1'b0, 64'h0);
            end
            if (cyc == 67) chk("b2b_second_done_image", {63'(s.chain[31:0]), s.done}, {63'hC3B4A596, 1'b1});
        end

        // Reset asserted mid-shift takes effect before the next edge.
        stuck_a = 1'b0;
        wait_ready(0);
        drive(0, 1'b1, 64'hFFFFFFFF);
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 1) drive(0, 1'b0, 64'h0);
        end
        get_sig(0, s);
        chk("pre_reset_shifting", 64'({s.ce, s.cdi}), 64'b11);
        #2 rst = 1'b1;
        #1 get_sig(0, s);
        chk("async_reset_outputs", 64'({s.ce, s.cdi, s.ready, s.busy, s.done}), 64'b00100);
        #3 rst = 1'b0;

        // Idle with no requests: nothing moves on any instance.
        bad = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) begin
                get_sig(k, s);
                if (s.ce || s.cdi || s.done) bad++;
            end
        end
        chk("idle_quiet", 64'(bad), 64'd0);

        rv = '{0, 64'hA5A5A5A5, 1'b0, 64'hA5A5A5A5, 64'hA5A5A5A5, 1'b0};
        run_vec(rv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/cfglut5_loader.md
Name: cfglut5_loader

Overview:
Serial configuration writer for a daisy chain of CFGLUT5-style reconfigurable 5-input LUTs. It accepts 32-bit truth-table words per LUT over a valid/ready handshake and shifts them out MSB-first on CDI with CE asserted. It can optionally read the chain back through CDO, recirculating the data so the contents are preserved, and flag any mismatch. It sits between soft logic (register file or sequencer) and the primitive chain.

Parameters:
LUT_CNT, 1, number of chained LUTs (CDO of LUT k drives CDI of LUT k+1); total chain length L = 32*LUT_CNT bits.
VERIFY, 1, 1 = perform a readback/recirculate pass after the load pass; 0 = load only.

Ports:
CLK  input  1  rising-edge clock, shared with the LUT chain.
RST  input  1  asynchronous, active-high reset.
S_VALID  input  1  new configuration available.
S_READY  output  1  loader idle; accepts S_INIT on this cycle.
S_INIT  input  L  configuration; LUT k (k = 0 nearest the loader) receives S_INIT[32k+31:32k].
CFG_CE  output  1  shift enable to every LUT in the chain.
CFG_CDI  output  1  serial data into LUT 0.
CFG_CDO  input  1  serial data out of LUT LUT_CNT-1 (combinational bit 31 of that LUT).
BUSY  output  1  high in SHIFT and VERIFY.
DONE  output  1  one-cycle pulse when the operation completes.
ERR  output  1  readback mismatch; sticky until the next accept.

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; S_READY=1; CFG_CE=0; CFG_CDI=0; BUSY=0; DONE=0; ERR=0; counter and shift registers = 0.
- States: IDLE, SHIFT, VERIFY, FIN.
- IDLE: S_READY=1, CFG_CE=0, CFG_CDI=0.
  - On S_VALID&S_READY, capture S_INIT into the data shift register and the shadow register, clear ERR, load counter = L-1, go to SHIFT.
- SHIFT: CFG_CE=1; CFG_CDI = data shift register MSB (registered).
  - Shift left by one each cycle and decrement the counter.
  - CE is high for exactly L consecutive cycles.
  - MSB-first order: S_INIT[L-1] is sent first and ends up as bit 31 of LUT LUT_CNT-1.
  - At count 0: go to VERIFY if VERIFY=1 (reload counter = L-1), else go to FIN.
- VERIFY: CFG_CE=1; CFG_CDI = CFG_CDO (combinational recirculate path, so the contents are unchanged after L shifts).
  - Each cycle, compare CFG_CDO with the shadow MSB, then shift the shadow left.
  - Any mismatch sets ERR (registered, visible from the next cycle).
  - At count 0, go to FIN.
- FIN: single cycle; DONE=1, CFG_CE=0; then IDLE. S_READY stays low in FIN.
- Timing for LUT_CNT=1, VERIFY=1, accept at edge 0:
  - CE high cycles 1–32 (load), 33–64 (verify).
  - DONE high in cycle 65; S_READY high from cycle 66.
- Timing with VERIFY=0: DONE in cycle 33.
- While not IDLE, S_READY=0 and S_VALID/S_INIT are ignored; the captured copy is stable.
- Back-to-back: S_VALID held high is accepted on the first IDLE cycle; there is no bubble beyond FIN.
- Reset during SHIFT/VERIFY: CE drops asynchronously and the chain holds partial contents; no DONE is issued. Software must reload.
- CDI is 0 whenever CE=0; CE never glitches high outside SHIFT/VERIFY.
- Counter width: clog2(L); it wraps only by reload, never free-runs.

Test Plan:
1. LUT_CNT=1, VERIFY=1, S_INIT=32'hDEADBEEF, behavioural CFGLUT5 model:
   - CE high for 64 cycles; CDI sequence starts 1,1,0,1,1,1,1,0.
   - Model INIT = DEADBEEF after cycle 32 and still after cycle 64.
   - DONE pulse in cycle 65; ERR=0.
2. Model with bit 7 stuck-at-0, load 32'hFFFFFFFF:
   - ERR=1 after the verify pass, DONE pulses.
   - ERR clears on the next accept of 32'h0000FFFF.
3. LUT_CNT=2, S_INIT=64'h12345678_9ABCDEF0:
   - CE high 64+64 cycles.
   - LUT1 = 12345678, LUT0 = 9ABCDEF0; ERR=0.
4. VERIFY=0, S_VALID held high with two words A then B:
   - DONE at cycle 33; second accept at cycle 34.
   - S_INIT changes while busy have no effect.
5. Assert RST in SHIFT cycle 10:
   - CE/CDI = 0 in the same cycle (before the clock edge).
   - S_READY=1, no DONE; a subsequent load of 32'hA5A5A5A5 completes correctly.
6. Idle check: S_VALID=0 for 100 cycles → CE=0, CDI=0, DONE never asserted.
